// File: rtl/sha256_multiblock.sv
// SHA-256 engine over a MSG_WORDS-word message held in shared word memory.
// Pads on the fly, pipelines reads and keeps only a 16-word rolling schedule.
module sha256_multiblock #(
    parameter int MSG_WORDS   = 20,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, LOAD, COMP, UPD, WR} state_t;

    localparam int          NB_INT    = (MSG_WORDS + 2) / 16 + 1;
    localparam logic [11:0] NB        = 12'(NB_INT);
    localparam logic [15:0] MW16      = 16'(MSG_WORDS);
    localparam logic [15:0] LAST_J    = 16'(16 * NB_INT - 1);
    localparam logic [31:0] BITLEN    = 32'(MSG_WORDS * 32);
    localparam logic [6:0]  LAT7      = 7'(MEM_LATENCY);
    localparam logic [6:0]  LOAD_LAST = 7'(16 + MEM_LATENCY - 1);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state, state_nxt;
    logic [6:0]  cnt;
    logic [11:0] blk, blk_nxt;
    logic [15:0] msg_base, out_base;
    logic [31:0] hreg [8];
    logic [31:0] work [8];
    logic [31:0] w [16];

    logic [31:0] t1, t2, w_new, slot_val;
    logic [3:0]  cap_slot;
    logic [15:0] slot_idx;

    assign mem_clk = clk;

    // Round arithmetic, schedule expansion and padded-stream word selection.
    always_comb begin
        t1 = work[7] + bsig1(work[4])
           + ((work[4] & work[5]) ^ (~work[4] & work[6]))
           + K[cnt[5:0]] + w[0];
        t2 = bsig0(work[0])
           + ((work[0] & work[1]) ^ (work[0] & work[2]) ^ (work[1] & work[2]));
        w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
        blk_nxt = blk + 12'd1;
        cap_slot = 4'(cnt - LAT7);
        slot_idx = {blk, cap_slot};
        if (slot_idx < MW16)
            slot_val = mem_read_data;
        else if (slot_idx == MW16)
            slot_val = 32'h80000000;
        else if (slot_idx == LAST_J)
            slot_val = BITLEN;
        else
            slot_val = 32'h0;
    end

    // State register; reset aborts any run immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and memory-port drive.
    always_comb begin
        state_nxt      = state;
        done           = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 16'h0;
        mem_write_data = 32'h0;
        unique case (state)
            IDLE: begin
                done = 1'b1;
                if (start)
                    state_nxt = LOAD;
            end
            LOAD: begin
                if (cnt < 7'd16)
                    mem_addr = msg_base + {blk, cnt[3:0]};
                if (cnt == LOAD_LAST)
                    state_nxt = COMP;
            end
            COMP: begin
                if (cnt == 7'd63)
                    state_nxt = UPD;
            end
            UPD: begin
                state_nxt = (blk_nxt < NB) ? LOAD : WR;
            end
            WR: begin
                mem_we         = 1'b1;
                mem_addr       = out_base + 16'(cnt[2:0]);
                mem_write_data = hreg[cnt[2:0]];
                if (cnt == 7'd7)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: hash state, working vars, rolling schedule, counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            blk      <= '0;
            msg_base <= '0;
            out_base <= '0;
            for (int k = 0; k < 8; k++) begin
                hreg[k] <= '0;
                work[k] <= '0;
            end
            for (int k = 0; k < 16; k++)
                w[k] <= '0;
        end else begin
            cnt <= (state_nxt != state) ? 7'd0 : cnt + 7'd1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 8; k++)
                            hreg[k] <= IV[k];
                        blk      <= '0;
                        msg_base <= message_addr;
                        out_base <= output_addr;
                    end
                end
                LOAD: begin
                    if (cnt == 7'd0)
                        for (int k = 0; k < 8; k++)
                            work[k] <= hreg[k];
                    if (cnt >= LAT7) begin
                        for (int k = 0; k < 15; k++)
                            w[k] <= w[k+1];
                        w[15] <= slot_val;
                    end
                end
                COMP: begin
                    work[0] <= t1 + t2;
                    work[1] <= work[0];
                    work[2] <= work[1];
                    work[3] <= work[2];
                    work[4] <= work[3] + t1;
                    work[5] <= work[4];
                    work[6] <= work[5];
                    work[7] <= work[6];
                    for (int k = 0; k < 15; k++)
                        w[k] <= w[k+1];
                    w[15] <= w_new;
                end
                UPD: begin
                    for (int k = 0; k < 8; k++)
                        hreg[k] <= hreg[k] + work[k];
                    blk <= blk_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_multiblock.sv
// Bench for sha256_multiblock: several length/latency builds share one memory.
// Digests come from a plain FIPS 180-4 model; timing from the latency formula.
module tb_sha256_multiblock;

    localparam int N = 6;
    localparam int MWS  [N] = '{0, 20, 13, 14, 16, 4};
    localparam int LATS [N] = '{1, 1, 2, 1, 3, 4};

    localparam logic [255:0] EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int          inst;
        logic [15:0] ma;
        logic [15:0] oa;
        int          busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] message_addr = 16'h0;
    logic [15:0] output_addr = 16'h0;
    logic [31:0] mem [65536];

    logic        start_v [N];
    logic        done_v  [N];
    logic        mclk_v  [N];
    logic        we_v    [N];
    logic [15:0] addr_v  [N];
    logic [31:0] wd_v    [N];
    logic [31:0] rd_v    [N];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = LATS[g];
        logic [31:0] pipe [L];

        always @(posedge clk) begin
            pipe[0] <= mem[addr_v[g]];
            for (int k = 1; k < L; k++)
                pipe[k] <= pipe[k-1];
        end

        assign rd_v[g] = pipe[L-1];

        sha256_multiblock #(
            .MSG_WORDS(MWS[g]),
            .MEM_LATENCY(L)
        ) u_dut (
            .clk(clk),
            .reset_n(reset_n),
            .start(start_v[g]),
            .message_addr(message_addr),
            .output_addr(output_addr),
            .done(done_v[g]),
            .mem_clk(mclk_v[g]),
            .mem_we(we_v[g]),
            .mem_addr(addr_v[g]),
            .mem_write_data(wd_v[g]),
            .mem_read_data(rd_v[g])
        );
    end

    task automatic check(input string name, input logic [255:0] got,
                         input logic [255:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic int busy_of(input int i);
        return ((MWS[i] + 2) / 16 + 1) * (81 + LATS[i]) + 8;
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_ref(input int mw, input logic [15:0] ma);
        logic [31:0] q[$];
        logic [31:0] h [8];
        logic [31:0] wv [64];
        logic [31:0] a, b, c, d, e, f, g, hh, x1, x2;
        for (int j = 0; j < mw; j++)
            q.push_back(mem[16'(int'(ma) + j)]);
        q.push_back(32'h80000000);
        while (q.size() % 16 != 14)
            q.push_back(32'h0);
        q.push_back(32'h0);
        q.push_back(32'(mw * 32));
        for (int k = 0; k < 8; k++)
            h[k] = IV[k];
        for (int bl = 0; bl < q.size() / 16; bl++) begin
            for (int t = 0; t < 16; t++)
                wv[t] = q[16 * bl + t];
            for (int t = 16; t < 64; t++)
                wv[t] = (rr(wv[t-2], 17) ^ rr(wv[t-2], 19) ^ (wv[t-2] >> 10))
                      + wv[t-7]
                      + (rr(wv[t-15], 7) ^ rr(wv[t-15], 18) ^ (wv[t-15] >> 3))
                      + wv[t-16];
            a = h[0]; b = h[1]; c = h[2]; d = h[3];
            e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                x1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25))
                   + ((e & f) ^ (~e & g)) + K[t] + wv[t];
                x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22))
                   + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + x1;
                d = c; c = b; b = a; a = x1 + x2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d;
            h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    // Watches one run from the cycle after the start edge until done.
    task automatic monitor(input int i, input logic [15:0] ma,
                           input logic [15:0] oa, input int exp_busy,
                           input logic [255:0] exp, input bit hold,
                           input bit stray, output logic [255:0] got);
        int k, p, b, c, bad_rd, bad_wr;
        logic [15:0] wa[$];
        logic [31:0] wdq[$];
        int wc[$];
        k = 0;
        bad_rd = 0;
        p = 81 + LATS[i];
        while (k < 3000) begin
            @(negedge clk);
            if (done_v[i])
                break;
            b = k / p;
            c = k % p;
            if (c < 16 && 16 * b + c < MWS[i])
                if (addr_v[i] !== 16'(int'(ma) + 16 * b + c))
                    bad_rd++;
            if (we_v[i]) begin
                wa.push_back(addr_v[i]);
                wdq.push_back(wd_v[i]);
                wc.push_back(k);
            end
            if (k == 0 && !hold) begin
                start_v[i] = 1'b0;
                message_addr = 16'($urandom);
                output_addr = 16'($urandom);
            end
            if (stray && k == 50)
                start_v[i] = 1'b1;
            if (stray && k == 51)
                start_v[i] = 1'b0;
            k++;
        end
        check("busy_cycles", 256'(k), 256'(exp_busy));
        check("read_addr_errors", 256'(bad_rd), 256'(0));
        bad_wr = (wa.size() != 8) ? 1 : 0;
        for (int j = 0; j < wa.size(); j++)
            if (j >= 8 || wa[j] !== 16'(int'(oa) + j) || wc[j] != exp_busy - 8 + j)
                bad_wr++;
        check("write_seq_errors", 256'(bad_wr), 256'(0));
        got = '0;
        for (int j = 0; j < 8 && j < wa.size(); j++)
            got[255 - 32 * j -: 32] = wdq[j];
        check("digest", got, exp);
    endtask

    task automatic run_vec(input int i, input logic [15:0] ma,
                           input logic [15:0] oa, input int exp_busy,
                           input bit stray);
        logic [255:0] exp, got;
        for (int j = 0; j < MWS[i]; j++)
            mem[16'(int'(ma) + j)] = $urandom;
        exp = sha_ref(MWS[i], ma);
        @(negedge clk);
        message_addr = ma;
        output_addr = oa;
        start_v[i] = 1'b1;
        monitor(i, ma, oa, exp_busy, exp, 1'b0, stray, got);
        if (i == 0)
            check("empty_digest", got, EMPTY);
    endtask

    vec_t vt [8];

    initial begin
        int bad, quiet, ri;
        logic [255:0] exp, got;
        logic [15:0] ma, oa;
        for (int i = 0; i < N; i++)
            start_v[i] = 1'b0;

        vt[0] = '{0, 16'h0100, 16'h0200, 90};
        vt[1] = '{1, 16'h1000, 16'h2000, 172};
        vt[2] = '{2, 16'h1100, 16'h2100, 91};
        vt[3] = '{3, 16'h1200, 16'h2200, 172};
        vt[4] = '{4, 16'h3000, 16'h3100, 176};
        vt[5] = '{5, 16'hFFFE, 16'hFFFC, 93};
        vt[6] = '{1, 16'h4000, 16'h4010, 172};
        vt[7] = '{3, 16'h5000, 16'h0008, 172};

        #1;
        bad = 0;
        for (int i = 0; i < N; i++)
            if (done_v[i] !== 1'b1 || we_v[i] !== 1'b0 ||
                addr_v[i] !== 16'h0 || wd_v[i] !== 32'h0)
                bad++;
        check("reset_state", 256'(bad), 256'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 8; v++)
            run_vec(vt[v].inst, vt[v].ma, vt[v].oa, vt[v].busy, 1'b0);

        run_vec(1, 16'h6000, 16'h6100, 172, 1'b1);

        ma = 16'h7000;
        oa = 16'h7100;
        for (int j = 0; j < MWS[2]; j++)
            mem[16'(int'(ma) + j)] = $urandom;
        exp = sha_ref(MWS[2], ma);
        @(negedge clk);
        message_addr = ma;
        output_addr = oa;
        start_v[2] = 1'b1;
        monitor(2, ma, oa, 91, exp, 1'b1, 1'b0, got);
        monitor(2, ma, oa, 91, exp, 1'b0, 1'b0, got);

        ma = 16'h8000;
        oa = 16'h8100;
        @(negedge clk);
        message_addr = ma;
        output_addr = oa;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (40) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check("abort_now", 256'({done_v[1], we_v[1], addr_v[1]}),
                 256'({1'b1, 1'b0, 16'h0}));
        quiet = 0;
        start_v[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (!done_v[1] || we_v[1])
                quiet++;
        end
        start_v[1] = 1'b0;
        reset_n = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (!done_v[1] || we_v[1])
                quiet++;
        end
        check("abort_quiet", 256'(quiet), 256'(0));
        run_vec(1, ma, oa, 172, 1'b0);

        repeat (6) begin
            ri = $urandom_range(0, N - 1);
            ma = 16'($urandom);
            oa = ma + 16'h0800;
            run_vec(ri, ma, oa, busy_of(ri), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
